// File: rtl/fifo.sv
// fifo -- single-clock synchronous FIFO with a registered read port.
//
// Stores up to 2**ADDRESS_WIDTH words of DATA_WIDTH bits and returns them
// in the order they were written. A read loads the oldest word into rdata
// on the accepting edge. rdata then holds that value until the next
// accepted read.
//
// Ports:
//   clk    in   1           single clock, rising edge active
//   rst    in   1           asynchronous active-low reset
//   wr     in   1           write request, ignored while full
//   rd     in   1           read request, ignored while empty
//   wdata  in   DATA_WIDTH  write data
//   rdata  out  DATA_WIDTH  registered read data
//   empty  out  1           FIFO holds no entries
//   full   out  1           FIFO holds 2**ADDRESS_WIDTH entries
module fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDRESS_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     wrEn, rdEn;

  // The flags come from the registered count only. This keeps the request
  // inputs off any combinational path to the outputs.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign rdata = rdata_q;

  // Acceptance uses the flag values from before the edge. When both
  // requests arrive while empty, only the write is accepted, so the new
  // word never bypasses the memory into rdata. When both arrive while
  // full, only the read is accepted.
  assign wrEn = wr & ~full;
  assign rdEn = rd & ~empty;

  // Next-state logic. The pointers are exactly ADDRESS_WIDTH bits wide, so
  // they wrap modulo the depth without any extra logic.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdEn) begin
      rdPtr_d = rdPtr_q + 1'b1;
      rdata_d = mem[rdPtr_q];
    end
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state. Reset clears it asynchronously. Clearing the count makes
  // every stale memory entry unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  // The storage array has no reset so it can map onto plain RAM. A write
  // and a read never target the same entry on one edge, because a
  // simultaneous write and read only occur when 0 < count < depth.
  always_ff @(posedge clk) begin
    if (wrEn && rst) begin
      mem[wrPtr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo -- directed self-checking bench for the fifo block.
//
// Drives a fixed sequence of requests and compares rdata, empty and full
// with values worked out by hand. Outputs are sampled 1 time unit after
// each rising edge. The bench covers reset, ordering, full and empty
// limits, simultaneous requests and pointer wrap.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       empty;
  logic       full;

  int checks;
  int passed;

  fifo #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .rd   (rd),
    .wdata(wdata),
    .rdata(rdata),
    .empty(empty),
    .full (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops a runaway simulation. A timeout is reported as a failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Applies one set of requests for exactly one rising edge, then samples
  // just after that edge with the requests dropped again.
  task automatic applyStimulus(input logic wrV, input logic rdV, input logic [7:0] dataV);
    wr    = wrV;
    rd    = rdV;
    wdata = dataV;
    @(posedge clk);
    #1;
    wr    = 1'b0;
    rd    = 1'b0;
    wdata = 8'h00;
  endtask

  // Compares all three observable outputs against the expected values.
  task automatic checkOutput(input string tag, input logic [7:0] rdataExp,
                             input logic emptyExp, input logic fullExp);
    checks++;
    assert (rdata === rdataExp) passed++;
    else $error("[TB] FAIL %s rdata: got %h expected %h", tag, rdata, rdataExp);
    checks++;
    assert (empty === emptyExp) passed++;
    else $error("[TB] FAIL %s empty: got %b expected %b", tag, empty, emptyExp);
    checks++;
    assert (full === fullExp) passed++;
    else $error("[TB] FAIL %s full: got %b expected %b", tag, full, fullExp);
  endtask

  logic [7:0] pattern [4];

  initial begin
    checks     = 0;
    passed     = 0;
    pattern[0] = 8'hAA;
    pattern[1] = 8'h55;
    pattern[2] = 8'hF0;
    pattern[3] = 8'h0F;
    wr         = 1'b0;
    rd         = 1'b0;
    wdata      = 8'h00;
    rst        = 1'b0;

    // The reset state is visible right away, and stays the same after
    // release when no edge has occurred yet.
    #3;
    checkOutput("reset_held", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_released", 8'h00, 1'b1, 1'b0);

    // Four writes leave rdata untouched. Four reads return the words in
    // write order, and the FIFO reports empty only after the last read.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, pattern[i]);
      checkOutput($sformatf("write4_%0d", i), 8'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("read4_%0d", i), pattern[i], (i == 3), 1'b0);
    end

    // A read while empty is ignored.
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("read_empty", 8'h0F, 1'b1, 1'b0);

    // Writes keep rdata at its last value. An asynchronous reset between
    // edges clears everything immediately.
    applyStimulus(1'b1, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h33);
    applyStimulus(1'b1, 1'b0, 8'h44);
    checkOutput("write_hold", 8'h0F, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 1'b1, 1'b0);
    #2;
    rst = 1'b1;

    // Fill to capacity, try one write too many, then drain. The rejected
    // 0xFF must never appear on rdata.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      checkOutput($sformatf("fill_%0d", i), 8'h00, 1'b0, (i == 255));
    end
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("write_full", 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("drain_%0d", i), 8'(i), (i == 255), 1'b0);
    end

    // A simultaneous write and read while empty accepts only the write,
    // so rdata keeps 0xFF from the drain.
    applyStimulus(1'b1, 1'b1, 8'hB0);
    checkOutput("wr_rd_empty", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wr_rd_empty_read", 8'hB0, 1'b1, 1'b0);

    // Both pointers now sit at 1. Moving them to 253 lets the next few
    // operations cross the wrap point.
    for (int i = 0; i < 252; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h00);
    end
    checkOutput("advance", 8'h00, 1'b1, 1'b0);

    // Three entries occupy slots 253..255. A simultaneous write and read
    // returns the oldest entry and stores the new word at slot 0.
    applyStimulus(1'b1, 1'b0, 8'hA1);
    applyStimulus(1'b1, 1'b0, 8'hA2);
    applyStimulus(1'b1, 1'b0, 8'hA3);
    applyStimulus(1'b1, 1'b1, 8'hA4);
    checkOutput("wr_rd_wrap", 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap_read_0", 8'hA2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap_read_1", 8'hA3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wrap_read_2", 8'hA4, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
